// File: rtl/lb2apb_pkg.sv
// Shared types for the LB-to-APB4 bridge: FSM state encoding and the
// width helper for the ACCESS-phase timeout counter.
package lb2apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } lb2apb_state_t;

  // clog2(timeout+1), never narrower than one bit so a disabled timeout still elaborates
  function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/lb2apb_timeout.sv
// ACCESS-phase watchdog: counts non-ready cycles and flags expiry on the
// cycle whose edge would make the count reach TIMEOUT.
module lb2apb_timeout
  import lb2apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  localparam int unsigned CW = tmo_cnt_w(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      logic [CW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          cnt <= '0;
        end else if (cnt_en) begin
          cnt <= cnt + 1'b1;
        end
      end

      // Abort on the edge that would register the TIMEOUT-th waiting cycle.
      assign expired = cnt_en && (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/lb2apb.sv
// LB-to-APB4 bridge: serves one LB write or read at a time as a single
// APB SETUP/ACCESS transfer and reports completion on one-cycle LB pulses.
module lb2apb
  import lb2apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned STRB_W  = DATA_W / 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lb_waddr,
  input  logic [DATA_W-1:0] lb_wdata,
  input  logic [STRB_W-1:0] lb_wstrb,
  input  logic              lb_wen,
  output logic              lb_wready,
  output logic              lb_werr,
  input  logic [ADDR_W-1:0] lb_raddr,
  input  logic              lb_ren,
  output logic [DATA_W-1:0] lb_rdata,
  output logic              lb_rvalid,
  output logic              lb_rerr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output lb2apb_state_t     dbg_state
);

  // Handshake: lb_wen/lb_ren are levels held by the requester until it samples
  // lb_wready/lb_rvalid (one-cycle pulses, err/rdata valid alongside); only IDLE
  // samples requests, write wins a tie, and APB completes on psel&penable&pready.

  lb2apb_state_t state;
  logic          tmo_expired;

  assign dbg_state = state;

  lb2apb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == SETUP),
    .cnt_en  ((state == ACCESS) && !pready),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      lb_wready <= 1'b0;
      lb_werr   <= 1'b0;
      lb_rvalid <= 1'b0;
      lb_rerr   <= 1'b0;
      lb_rdata  <= '0;
    end else begin
      lb_wready <= 1'b0;
      lb_werr   <= 1'b0;
      lb_rvalid <= 1'b0;
      lb_rerr   <= 1'b0;
      case (state)
        IDLE: begin
          if (lb_wen) begin
            paddr  <= lb_waddr;
            pwdata <= lb_wdata;
            pstrb  <= lb_wstrb;
            pwrite <= 1'b1;
            psel   <= 1'b1;
            state  <= SETUP;
          end else if (lb_ren) begin
            paddr  <= lb_raddr;
            pstrb  <= '0;
            pwrite <= 1'b0;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= RESP;
            if (pwrite) begin
              lb_wready <= 1'b1;
              lb_werr   <= pslverr;
            end else begin
              lb_rvalid <= 1'b1;
              lb_rerr   <= pslverr;
              lb_rdata  <= prdata;
            end
          end else if (tmo_expired) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= RESP;
            if (pwrite) begin
              lb_wready <= 1'b1;
              lb_werr   <= 1'b1;
            end else begin
              lb_rvalid <= 1'b1;
              lb_rerr   <= 1'b1;
              lb_rdata  <= '0;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lb2apb.sv
// Randomized bench for lb2apb: an APB slave with programmable wait states and
// errors, plus a transaction-level model of completion latency, data and error.
module tb_lb2apb;

  localparam int TIMEOUT = 8;

  logic        clk;
  logic        rst;
  logic [15:0] lb_waddr;
  logic [31:0] lb_wdata;
  logic [3:0]  lb_wstrb;
  logic        lb_wen;
  logic        lb_wready;
  logic        lb_werr;
  logic [15:0] lb_raddr;
  logic        lb_ren;
  logic [31:0] lb_rdata;
  logic        lb_rvalid;
  logic        lb_rerr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [1:0]  dbg_state;

  lb2apb #(
    .ADDR_W  (16),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lb_waddr  (lb_waddr),
    .lb_wdata  (lb_wdata),
    .lb_wstrb  (lb_wstrb),
    .lb_wen    (lb_wen),
    .lb_wready (lb_wready),
    .lb_werr   (lb_werr),
    .lb_raddr  (lb_raddr),
    .lb_ren    (lb_ren),
    .lb_rdata  (lb_rdata),
    .lb_rvalid (lb_rvalid),
    .lb_rerr   (lb_rerr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errs   = 0;
  logic [52:0] exp_q[$];        // {pwrite, paddr, pwdata, pstrb} per expected APB transfer
  logic [52:0] setup_snap;
  int          sl_waits = 0;
  bit          sl_err   = 0;
  logic [31:0] sl_rdata = '0;
  bit          stray    = 0;
  int          acc_n    = 0;
  int          wr_pulses = 0, rd_pulses = 0;
  int          exp_wr_pulses = 0, exp_rd_pulses = 0;
  logic [31:0] last_rd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- APB slave + bus monitor ----------------
  initial begin
    logic [52:0] e;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    forever begin
      @(negedge clk);
      if (lb_wready) wr_pulses++;
      if (lb_rvalid) rd_pulses++;
      if (psel && !penable) begin
        if (exp_q.size() == 0) begin
          check("apb_unexpected_setup", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("apb_pwrite", pwrite, e[52]);
          check("apb_paddr", paddr, e[51:36]);
          if (e[52]) check("apb_pwdata", pwdata, e[35:4]);
          check("apb_pstrb", pstrb, e[3:0]);
        end
        setup_snap = {pwrite, paddr, pwdata, pstrb};
      end
      if (psel && penable) begin
        check("apb_stable", {pwrite, paddr, pwdata, pstrb}, setup_snap);
        pready  = (acc_n == sl_waits);
        pslverr = pready && sl_err;
        prdata  = pready ? sl_rdata : 32'($urandom);
        acc_n++;
      end else begin
        acc_n   = 0;
        pready  = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        pslverr = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        prdata  = 32'($urandom);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input bit wr, input bit scramble, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (scramble) begin
        if (wr) begin
          lb_waddr = 16'($urandom);
          lb_wdata = 32'($urandom);
          lb_wstrb = 4'($urandom);
        end else begin
          lb_raddr = 16'($urandom);
        end
      end
    end while (!(wr ? lb_wready : lb_rvalid) && lat < 64);
  endtask

  task automatic lb_txn(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int waits, input bit err);
    int          lat;
    bit          tmo;
    logic [31:0] exp_rd;
    tmo      = (waits >= TIMEOUT);
    exp_rd   = tmo ? 32'h0 : data;
    sl_waits = waits;
    sl_err   = err;
    sl_rdata = data;
    exp_q.push_back({wr, addr, data, wr ? strb : 4'h0});
    @(negedge clk);
    if (wr) begin
      lb_wen = 1'b1; lb_waddr = addr; lb_wdata = data; lb_wstrb = strb;
    end else begin
      lb_ren = 1'b1; lb_raddr = addr;
    end
    wait_done(wr, 1'b1, lat);
    if (wr) begin
      check("wr_latency", lat, tmo ? 2 + TIMEOUT : 3 + waits);
      check("werr", lb_werr, tmo | err);
      exp_wr_pulses++;
    end else begin
      check("rd_latency", lat, tmo ? 2 + TIMEOUT : 3 + waits);
      check("rerr", lb_rerr, tmo | err);
      check("rdata", lb_rdata, exp_rd);
      last_rd = exp_rd;
      exp_rd_pulses++;
    end
    @(posedge clk);
    #1;
    lb_wen = 1'b0;
    lb_ren = 1'b0;
    check("pulse_one_cycle", {lb_wready, lb_rvalid}, 0);
    check("rdata_hold", lb_rdata, last_rd);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    rst = 1'b1;
    lb_wen = 1'b0; lb_ren = 1'b0;
    lb_waddr = '0; lb_wdata = '0; lb_wstrb = '0; lb_raddr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {psel, penable, pwrite, pstrb, lb_wready, lb_werr, lb_rvalid, lb_rerr}, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rdata", lb_rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    lb_txn(1'b1, 16'h0030, 32'hdeadbeef, 4'hF, 0, 1'b0);
    lb_txn(1'b0, 16'h0030, 32'h0000dead, 4'h0, 2, 1'b0);

    // Simultaneous write and read: write first, read starts right after RESP
    sl_waits = 0; sl_err = 0;
    exp_q.push_back({1'b1, 16'h0010, 32'h11112222, 4'hF});
    exp_q.push_back({1'b0, 16'h0014, 32'h0, 4'h0});
    @(negedge clk);
    lb_wen = 1'b1; lb_waddr = 16'h0010; lb_wdata = 32'h11112222; lb_wstrb = 4'hF;
    lb_ren = 1'b1; lb_raddr = 16'h0014;
    wait_done(1'b1, 1'b0, lat);
    check("dual_wr_latency", lat, 3);
    check("dual_werr", lb_werr, 0);
    exp_wr_pulses++;
    sl_rdata = 32'h0badcafe;
    @(posedge clk);
    #1;
    lb_wen = 1'b0;
    wait_done(1'b0, 1'b0, lat);
    check("dual_rd_gap", lat + 1, 4);
    check("dual_rdata", lb_rdata, 32'h0badcafe);
    check("dual_rerr", lb_rerr, 0);
    last_rd = 32'h0badcafe;
    exp_rd_pulses++;
    @(posedge clk);
    #1;
    lb_ren = 1'b0;

    // Slave error, then a clean read
    lb_txn(1'b0, 16'h0020, 32'h12345678, 4'h0, 0, 1'b1);
    lb_txn(1'b0, 16'h0024, 32'h87654321, 4'h0, 1, 1'b0);

    // Timeout boundary: one wait short of expiry, then a dead slave
    lb_txn(1'b0, 16'h0040, 32'hcafef00d, 4'h0, TIMEOUT - 1, 1'b0);
    lb_txn(1'b0, 16'h0044, 32'hffffffff, 4'h0, TIMEOUT, 1'b0);
    lb_txn(1'b0, 16'h0048, 32'haaaa5555, 4'h0, 40, 1'b0);
    stray = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    stray = 1'b0;
    lb_txn(1'b1, 16'h004c, 32'h01020304, 4'h5, 50, 1'b0);

    // Reset while in ACCESS abandons the transfer without a completion pulse
    sl_waits = 5; sl_err = 0;
    exp_q.push_back({1'b1, 16'h0050, 32'h55667788, 4'h3});
    @(negedge clk);
    lb_wen = 1'b1; lb_waddr = 16'h0050; lb_wdata = 32'h55667788; lb_wstrb = 4'h3;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_access", {psel, penable}, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_apb", {psel, penable, pwrite, pstrb}, 0);
    check("mid_rst_pulses", {lb_wready, lb_rvalid, lb_werr, lb_rerr}, 0);
    check("mid_rst_rdata", lb_rdata, 0);
    last_rd = '0;
    lb_wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    lb_txn(1'b1, 16'h0054, 32'h9abcdef0, 4'hF, 1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int w;
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 4)
                                      : $urandom_range(0, 3);
      lb_txn(1'($urandom_range(0, 1)), 16'($urandom), 32'($urandom), 4'($urandom),
             w, 1'($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clk);
    #1;
    check("wr_pulse_count", wr_pulses, exp_wr_pulses);
    check("rd_pulse_count", rd_pulses, exp_rd_pulses);
    check("apb_transfers_left", exp_q.size(), 0);
    check("final_rdata_hold", lb_rdata, last_rd);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
